// File: rtl/xbar_pkg.sv
// Shared types and sizing for the 4x4 out-of-order crossbar.
package xbar_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned ROB_DEPTH = 4;
  localparam int unsigned ADDR_BITS = 32;
  localparam int unsigned DATA_BITS = 32;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic                 cmd;
    logic [DATA_BITS-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [1:0]           slave_id;
    logic                 done;
    logic [DATA_BITS-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/xbar_rob.sv
// Per-master reorder buffer: allocates in request order, fills from any slave, delivers in order.
module xbar_rob
  import xbar_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 alloc,
  input  logic [1:0]                           alloc_slave,
  input  logic [NUM_PORTS-1:0]                 fill_valid,
  input  logic [NUM_PORTS-1:0][DATA_BITS-1:0] fill_data,
  output logic                                 full,
  output logic                                 resp,
  output logic [DATA_BITS-1:0]                 rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rob_entry_t entries [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;
  logic [NUM_PORTS-1:0]         hit;
  logic [NUM_PORTS-1:0][PW-1:0] hit_idx;
  logic                         head_fill, pop;
  logic [DATA_BITS-1:0]         head_data;

  // Each slave returns in order, so its fill targets the oldest pending entry tagged with it.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    idx     = '0;
    for (int unsigned s = 0; s < NUM_PORTS; s++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if (fill_valid[s] && !hit[s] && (CW'(i) < count) &&
            !entries[idx].done && (entries[idx].slave_id == 2'(s))) begin
          hit[s]     = 1'b1;
          hit_idx[s] = idx;
        end
      end
    end
  end

  // A fill landing on the head is forwarded straight into the response register.
  always_comb begin
    head_fill = 1'b0;
    head_data = entries[head].data;
    for (int unsigned s = 0; s < NUM_PORTS; s++) begin
      if (hit[s] && (hit_idx[s] == head)) begin
        head_fill = 1'b1;
        head_data = fill_data[s];
      end
    end
  end

  assign pop  = (count != '0) && (entries[head].done || head_fill);
  assign full = (count == CW'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      resp  <= 1'b0;
      rdata <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i].done <= 1'b0;
      end
    end else begin
      for (int unsigned s = 0; s < NUM_PORTS; s++) begin
        if (hit[s]) begin
          entries[hit_idx[s]].done <= 1'b1;
          entries[hit_idx[s]].data <= fill_data[s];
        end
      end
      if (alloc) begin
        entries[tail] <= '{slave_id: alloc_slave, done: 1'b0, data: '0};
        tail          <= tail + 1'b1;
      end
      resp <= pop;
      if (pop) begin
        rdata <= head_data;
        head  <= head + 1'b1;
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  orphan_resp: assert property (@(posedge clk_i) disable iff (rst_i) (fill_valid & ~hit) == '0);

endmodule

// File: rtl/xbar_ooo_4x4.sv
// 4-master x 4-slave crossbar: address-routed, round-robin per slave, in-order read return per master.
module xbar_ooo_4x4 #(
  parameter int unsigned ROB_DEPTH = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              master_0_req,
  input  logic [ADDR_W-1:0] master_0_addr,
  input  logic              master_0_cmd,
  input  logic [DATA_W-1:0] master_0_wdata,
  output logic              master_0_ack,
  output logic [DATA_W-1:0] master_0_rdata,
  output logic              master_0_resp,
  input  logic              master_1_req,
  input  logic [ADDR_W-1:0] master_1_addr,
  input  logic              master_1_cmd,
  input  logic [DATA_W-1:0] master_1_wdata,
  output logic              master_1_ack,
  output logic [DATA_W-1:0] master_1_rdata,
  output logic              master_1_resp,
  input  logic              master_2_req,
  input  logic [ADDR_W-1:0] master_2_addr,
  input  logic              master_2_cmd,
  input  logic [DATA_W-1:0] master_2_wdata,
  output logic              master_2_ack,
  output logic [DATA_W-1:0] master_2_rdata,
  output logic              master_2_resp,
  input  logic              master_3_req,
  input  logic [ADDR_W-1:0] master_3_addr,
  input  logic              master_3_cmd,
  input  logic [DATA_W-1:0] master_3_wdata,
  output logic              master_3_ack,
  output logic [DATA_W-1:0] master_3_rdata,
  output logic              master_3_resp,
  output logic              slave_0_req,
  output logic [ADDR_W-1:0] slave_0_addr,
  output logic              slave_0_cmd,
  output logic [1:0]        slave_0_reqtid,
  output logic [DATA_W-1:0] slave_0_wdata,
  input  logic              slave_0_ack,
  input  logic [1:0]        slave_0_resptid,
  input  logic [DATA_W-1:0] slave_0_rdata,
  input  logic              slave_0_resp,
  output logic              slave_1_req,
  output logic [ADDR_W-1:0] slave_1_addr,
  output logic              slave_1_cmd,
  output logic [1:0]        slave_1_reqtid,
  output logic [DATA_W-1:0] slave_1_wdata,
  input  logic              slave_1_ack,
  input  logic [1:0]        slave_1_resptid,
  input  logic [DATA_W-1:0] slave_1_rdata,
  input  logic              slave_1_resp,
  output logic              slave_2_req,
  output logic [ADDR_W-1:0] slave_2_addr,
  output logic              slave_2_cmd,
  output logic [1:0]        slave_2_reqtid,
  output logic [DATA_W-1:0] slave_2_wdata,
  input  logic              slave_2_ack,
  input  logic [1:0]        slave_2_resptid,
  input  logic [DATA_W-1:0] slave_2_rdata,
  input  logic              slave_2_resp,
  output logic              slave_3_req,
  output logic [ADDR_W-1:0] slave_3_addr,
  output logic              slave_3_cmd,
  output logic [1:0]        slave_3_reqtid,
  output logic [DATA_W-1:0] slave_3_wdata,
  input  logic              slave_3_ack,
  input  logic [1:0]        slave_3_resptid,
  input  logic [DATA_W-1:0] slave_3_rdata,
  input  logic              slave_3_resp
);

  import xbar_pkg::*;

  localparam int unsigned N = NUM_PORTS;

  req_t                         req_in [N];
  req_t                         s_out  [N];
  logic [N-1:0]                 m_req, m_ack, m_resp, rob_full, elig;
  logic [N-1:0][1:0]            tgt;
  logic [N-1:0][DATA_BITS-1:0]  m_rdata;
  logic [N-1:0]                 s_ack, s_resp, gnt_vld;
  logic [N-1:0][1:0]            s_resptid, winner, ptr;
  logic [N-1:0][DATA_BITS-1:0]  s_rdata;
  logic [1:0]                   idx;

  assign m_req = {master_3_req, master_2_req, master_1_req, master_0_req};
  assign req_in[0] = '{addr: master_0_addr, cmd: master_0_cmd, wdata: master_0_wdata};
  assign req_in[1] = '{addr: master_1_addr, cmd: master_1_cmd, wdata: master_1_wdata};
  assign req_in[2] = '{addr: master_2_addr, cmd: master_2_cmd, wdata: master_2_wdata};
  assign req_in[3] = '{addr: master_3_addr, cmd: master_3_cmd, wdata: master_3_wdata};

  assign s_ack     = {slave_3_ack, slave_2_ack, slave_1_ack, slave_0_ack};
  assign s_resp    = {slave_3_resp, slave_2_resp, slave_1_resp, slave_0_resp};
  assign s_resptid = {slave_3_resptid, slave_2_resptid, slave_1_resptid, slave_0_resptid};
  assign s_rdata   = {slave_3_rdata, slave_2_rdata, slave_1_rdata, slave_0_rdata};

  always_comb begin
    for (int unsigned m = 0; m < N; m++) begin
      tgt[m]  = req_in[m].addr[ADDR_BITS-1 -: 2];
      elig[m] = m_req[m] && (req_in[m].cmd || !rob_full[m]);
    end
  end

  // Round-robin search starts at each slave's pointer; grants are held off while in reset.
  always_comb begin
    gnt_vld = '0;
    winner  = '0;
    idx     = '0;
    for (int unsigned s = 0; s < N; s++) begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = ptr[s] + 2'(i);
        if (!rst_i && !gnt_vld[s] && elig[idx] && (tgt[idx] == 2'(s))) begin
          gnt_vld[s] = 1'b1;
          winner[s]  = idx;
        end
      end
      s_out[s] = gnt_vld[s] ? req_in[winner[s]] : '0;
    end
  end

  always_comb begin
    m_ack = '0;
    for (int unsigned m = 0; m < N; m++) begin
      for (int unsigned s = 0; s < N; s++) begin
        if (gnt_vld[s] && s_ack[s] && (winner[s] == 2'(m))) begin
          m_ack[m] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else begin
      for (int unsigned s = 0; s < N; s++) begin
        if (gnt_vld[s] && s_ack[s]) begin
          ptr[s] <= winner[s] + 2'd1;
        end
      end
    end
  end

  for (genvar m = 0; m < N; m++) begin : g_rob
    logic [N-1:0] fill_valid;

    always_comb begin
      for (int unsigned s = 0; s < N; s++) begin
        fill_valid[s] = s_resp[s] && (s_resptid[s] == 2'(m));
      end
    end

    xbar_rob #(.DEPTH(ROB_DEPTH)) u_rob (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .alloc       (m_ack[m] && !req_in[m].cmd),
      .alloc_slave (tgt[m]),
      .fill_valid  (fill_valid),
      .fill_data   (s_rdata),
      .full        (rob_full[m]),
      .resp        (m_resp[m]),
      .rdata       (m_rdata[m])
    );
  end

  assign master_0_ack   = m_ack[0];
  assign master_1_ack   = m_ack[1];
  assign master_2_ack   = m_ack[2];
  assign master_3_ack   = m_ack[3];
  assign master_0_resp  = m_resp[0];
  assign master_1_resp  = m_resp[1];
  assign master_2_resp  = m_resp[2];
  assign master_3_resp  = m_resp[3];
  assign master_0_rdata = m_rdata[0];
  assign master_1_rdata = m_rdata[1];
  assign master_2_rdata = m_rdata[2];
  assign master_3_rdata = m_rdata[3];

  assign slave_0_req    = gnt_vld[0];
  assign slave_1_req    = gnt_vld[1];
  assign slave_2_req    = gnt_vld[2];
  assign slave_3_req    = gnt_vld[3];
  assign slave_0_reqtid = winner[0];
  assign slave_1_reqtid = winner[1];
  assign slave_2_reqtid = winner[2];
  assign slave_3_reqtid = winner[3];
  assign slave_0_addr   = s_out[0].addr;
  assign slave_1_addr   = s_out[1].addr;
  assign slave_2_addr   = s_out[2].addr;
  assign slave_3_addr   = s_out[3].addr;
  assign slave_0_cmd    = s_out[0].cmd;
  assign slave_1_cmd    = s_out[1].cmd;
  assign slave_2_cmd    = s_out[2].cmd;
  assign slave_3_cmd    = s_out[3].cmd;
  assign slave_0_wdata  = s_out[0].wdata;
  assign slave_1_wdata  = s_out[1].wdata;
  assign slave_2_wdata  = s_out[2].wdata;
  assign slave_3_wdata  = s_out[3].wdata;

endmodule

// File: tb/tb_xbar_ooo_4x4.sv
// Directed bench: arbitration vector table plus hand sequences for ROB ordering, full and reset.
module tb_xbar_ooo_4x4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_req [4];
  logic [31:0] m_addr [4];
  logic        m_cmd [4];
  logic [31:0] m_wdata [4];
  logic        m_ack [4];
  logic [31:0] m_rdata [4];
  logic        m_resp [4];
  logic        s_req [4];
  logic [31:0] s_addr [4];
  logic        s_cmd [4];
  logic [1:0]  s_reqtid [4];
  logic [31:0] s_wdata [4];
  logic        s_ack [4];
  logic [1:0]  s_resptid [4];
  logic [31:0] s_rdata [4];
  logic        s_resp [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xbar_ooo_4x4 dut (
    .clk_i(clk), .rst_i(rst),
    .master_0_req(m_req[0]), .master_0_addr(m_addr[0]), .master_0_cmd(m_cmd[0]), .master_0_wdata(m_wdata[0]),
    .master_0_ack(m_ack[0]), .master_0_rdata(m_rdata[0]), .master_0_resp(m_resp[0]),
    .master_1_req(m_req[1]), .master_1_addr(m_addr[1]), .master_1_cmd(m_cmd[1]), .master_1_wdata(m_wdata[1]),
    .master_1_ack(m_ack[1]), .master_1_rdata(m_rdata[1]), .master_1_resp(m_resp[1]),
    .master_2_req(m_req[2]), .master_2_addr(m_addr[2]), .master_2_cmd(m_cmd[2]), .master_2_wdata(m_wdata[2]),
    .master_2_ack(m_ack[2]), .master_2_rdata(m_rdata[2]), .master_2_resp(m_resp[2]),
    .master_3_req(m_req[3]), .master_3_addr(m_addr[3]), .master_3_cmd(m_cmd[3]), .master_3_wdata(m_wdata[3]),
    .master_3_ack(m_ack[3]), .master_3_rdata(m_rdata[3]), .master_3_resp(m_resp[3]),
    .slave_0_req(s_req[0]), .slave_0_addr(s_addr[0]), .slave_0_cmd(s_cmd[0]), .slave_0_reqtid(s_reqtid[0]),
    .slave_0_wdata(s_wdata[0]), .slave_0_ack(s_ack[0]), .slave_0_resptid(s_resptid[0]),
    .slave_0_rdata(s_rdata[0]), .slave_0_resp(s_resp[0]),
    .slave_1_req(s_req[1]), .slave_1_addr(s_addr[1]), .slave_1_cmd(s_cmd[1]), .slave_1_reqtid(s_reqtid[1]),
    .slave_1_wdata(s_wdata[1]), .slave_1_ack(s_ack[1]), .slave_1_resptid(s_resptid[1]),
    .slave_1_rdata(s_rdata[1]), .slave_1_resp(s_resp[1]),
    .slave_2_req(s_req[2]), .slave_2_addr(s_addr[2]), .slave_2_cmd(s_cmd[2]), .slave_2_reqtid(s_reqtid[2]),
    .slave_2_wdata(s_wdata[2]), .slave_2_ack(s_ack[2]), .slave_2_resptid(s_resptid[2]),
    .slave_2_rdata(s_rdata[2]), .slave_2_resp(s_resp[2]),
    .slave_3_req(s_req[3]), .slave_3_addr(s_addr[3]), .slave_3_cmd(s_cmd[3]), .slave_3_reqtid(s_reqtid[3]),
    .slave_3_wdata(s_wdata[3]), .slave_3_ack(s_ack[3]), .slave_3_resptid(s_resptid[3]),
    .slave_3_rdata(s_rdata[3]), .slave_3_resp(s_resp[3])
  );

  // tgt packs 2 bits per master, tid packs 2 bits per slave.
  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] cmd;
    logic [7:0] tgt;
    logic [3:0] sack;
    logic [3:0] mack;
    logic [3:0] sreq;
    logic [7:0] tid;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      m_req[i] = 1'b0; m_addr[i] = '0; m_cmd[i] = 1'b0; m_wdata[i] = '0;
      s_ack[i] = 1'b0; s_resptid[i] = '0; s_rdata[i] = '0; s_resp[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] tid;

    vecs[0]  = '{"idle",     4'b0000, 4'b0000, 8'hAA, 4'b0000, 4'b0000, 4'b0000, 8'h00};
    vecs[1]  = '{"rr_s2_m0", 4'b1111, 4'b0000, 8'hAA, 4'b0100, 4'b0001, 4'b0100, 8'h00};
    vecs[2]  = '{"rr_s2_m1", 4'b1111, 4'b0000, 8'hAA, 4'b0100, 4'b0010, 4'b0100, 8'h10};
    vecs[3]  = '{"rr_s2_m2", 4'b1111, 4'b0000, 8'hAA, 4'b0100, 4'b0100, 4'b0100, 8'h20};
    vecs[4]  = '{"rr_s2_m3", 4'b1111, 4'b0000, 8'hAA, 4'b0100, 4'b1000, 4'b0100, 8'h30};
    vecs[5]  = '{"rr_s2_wrap", 4'b1111, 4'b0000, 8'hAA, 4'b0100, 4'b0001, 4'b0100, 8'h00};
    vecs[6]  = '{"rr_noack", 4'b1111, 4'b0000, 8'hAA, 4'b0000, 4'b0000, 4'b0100, 8'h10};
    vecs[7]  = '{"rr_hold",  4'b1111, 4'b0000, 8'hAA, 4'b0100, 4'b0010, 4'b0100, 8'h10};
    vecs[8]  = '{"parallel", 4'b1111, 4'b1111, 8'hE4, 4'b1111, 4'b1111, 4'b1111, 8'hE4};
    vecs[9]  = '{"s0_m3",    4'b1001, 4'b1111, 8'h00, 4'b0001, 4'b1000, 4'b0001, 8'h03};
    vecs[10] = '{"s0_m0",    4'b1001, 4'b1111, 8'h00, 4'b0001, 4'b0001, 4'b0001, 8'h00};
    vecs[11] = '{"s3_noack", 4'b0110, 4'b1111, 8'h3C, 4'b0000, 4'b0000, 4'b1000, 8'h40};

    do_reset();
    #4;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_mack%0d", i), 32'(m_ack[i]), 32'd0);
      chk($sformatf("reset_mresp%0d", i), 32'(m_resp[i]), 32'd0);
      chk($sformatf("reset_mrdata%0d", i), m_rdata[i], 32'd0);
      chk($sformatf("reset_sreq%0d", i), 32'(s_req[i]), 32'd0);
    end

    // Arbitration table: vectors run in order, round-robin pointers carry between them.
    for (int v = 0; v < 12; v++) begin
      for (int m = 0; m < 4; m++) begin
        m_req[m]   = vecs[v].req[m];
        m_cmd[m]   = vecs[v].cmd[m];
        m_addr[m]  = {vecs[v].tgt[2*m +: 2], 30'h100 + 30'(m)};
        m_wdata[m] = 32'hD000_0000 + 32'(m);
        s_ack[m]   = vecs[v].sack[m];
      end
      #4;
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("%s_sreq%0d", vecs[v].name, s), 32'(s_req[s]), 32'(vecs[v].sreq[s]));
        chk($sformatf("%s_mack%0d", vecs[v].name, s), 32'(m_ack[s]), 32'(vecs[v].mack[s]));
        if (vecs[v].sreq[s]) begin
          tid = vecs[v].tid[2*s +: 2];
          chk($sformatf("%s_tid%0d", vecs[v].name, s), 32'(s_reqtid[s]), 32'(tid));
          chk($sformatf("%s_addr%0d", vecs[v].name, s), s_addr[s], {2'(s), 30'h100 + 30'(tid)});
          chk($sformatf("%s_cmd%0d", vecs[v].name, s), 32'(s_cmd[s]), 32'(vecs[v].cmd[tid]));
        end
      end
      step();
    end

    // Single read round trip through slave 1.
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h4000_0010; m_cmd[0] = 1'b0; s_ack[1] = 1'b1;
    #4;
    chk("single_sreq", 32'(s_req[1]), 32'd1);
    chk("single_saddr", s_addr[1], 32'h4000_0010);
    chk("single_tid", 32'(s_reqtid[1]), 32'd0);
    chk("single_mack", 32'(m_ack[0]), 32'd1);
    step();
    m_req[0] = 1'b0; s_ack[1] = 1'b0;
    step();
    s_resp[1] = 1'b1; s_resptid[1] = 2'd0; s_rdata[1] = 32'h4000_0010;
    #4;
    chk("single_resp_early", 32'(m_resp[0]), 32'd0);
    step();
    s_resp[1] = 1'b0;
    #4;
    chk("single_resp", 32'(m_resp[0]), 32'd1);
    chk("single_rdata", m_rdata[0], 32'h4000_0010);
    step();
    #4;
    chk("single_resp_once", 32'(m_resp[0]), 32'd0);

    // Reorder: slave0 answers before slave3, master 2 must still see slave3 data first.
    do_reset();
    m_req[2] = 1'b1; m_addr[2] = 32'hC000_0000; s_ack[3] = 1'b1;
    #4; chk("ooo_ack_a", 32'(m_ack[2]), 32'd1);
    step();
    s_ack[3] = 1'b0; m_addr[2] = 32'h0000_0004; s_ack[0] = 1'b1;
    #4; chk("ooo_ack_b", 32'(m_ack[2]), 32'd1);
    step();
    m_req[2] = 1'b0; s_ack[0] = 1'b0;
    s_resp[0] = 1'b1; s_resptid[0] = 2'd2; s_rdata[0] = 32'hA;
    step();
    s_resp[0] = 1'b0;
    #4; chk("ooo_hold", 32'(m_resp[2]), 32'd0);
    step();
    s_resp[3] = 1'b1; s_resptid[3] = 2'd2; s_rdata[3] = 32'hB;
    step();
    s_resp[3] = 1'b0;
    #4;
    chk("ooo_resp1", 32'(m_resp[2]), 32'd1);
    chk("ooo_data1", m_rdata[2], 32'hB);
    step();
    #4;
    chk("ooo_resp2", 32'(m_resp[2]), 32'd1);
    chk("ooo_data2", m_rdata[2], 32'hA);
    step();
    #4; chk("ooo_done", 32'(m_resp[2]), 32'd0);

    // ROB full: four reads accepted, fifth blocked until one is delivered.
    do_reset();
    m_req[1] = 1'b1; m_cmd[1] = 1'b0; s_ack[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_addr[1] = 32'h0000_0100 + 32'(4 * i);
      #4; chk($sformatf("full_ack%0d", i), 32'(m_ack[1]), 32'd1);
      step();
    end
    m_addr[1] = 32'h0000_0200;
    #4;
    chk("full_block_ack", 32'(m_ack[1]), 32'd0);
    chk("full_block_sreq", 32'(s_req[0]), 32'd0);
    step();
    m_cmd[1] = 1'b1;
    #4; chk("full_write_ok", 32'(m_ack[1]), 32'd1);
    step();
    m_cmd[1] = 1'b0;
    s_resp[0] = 1'b1; s_resptid[0] = 2'd1; s_rdata[0] = 32'h55;
    #4; chk("full_pop_cycle_ack", 32'(m_ack[1]), 32'd0);
    step();
    s_resp[0] = 1'b0;
    #4;
    chk("full_resp", 32'(m_resp[1]), 32'd1);
    chk("full_rdata", m_rdata[1], 32'h55);
    chk("full_resume_ack", 32'(m_ack[1]), 32'd1);
    step();
    m_req[1] = 1'b0;

    // Write: forwarded with cmd and tid, never produces a response or ROB entry.
    do_reset();
    m_req[3] = 1'b1; m_cmd[3] = 1'b1; m_addr[3] = 32'hC000_0FFC; m_wdata[3] = 32'hC000_0FFC; s_ack[3] = 1'b1;
    #4;
    chk("wr_sreq", 32'(s_req[3]), 32'd1);
    chk("wr_scmd", 32'(s_cmd[3]), 32'd1);
    chk("wr_tid", 32'(s_reqtid[3]), 32'd3);
    chk("wr_wdata", s_wdata[3], 32'hC000_0FFC);
    chk("wr_mack", 32'(m_ack[3]), 32'd1);
    step();
    m_req[3] = 1'b0; s_ack[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4; chk($sformatf("wr_noresp%0d", i), 32'(m_resp[3]), 32'd0);
      step();
    end
    chk("wr_count", 32'(dut.g_rob[3].u_rob.count), 32'd0);

    // Reset with three reads outstanding.
    do_reset();
    m_req[0] = 1'b1; m_cmd[0] = 1'b0; s_ack[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_addr[0] = 32'h4000_0000 + 32'(4 * i);
      step();
    end
    chk("rst_pending", 32'(dut.g_rob[0].u_rob.count), 32'd3);
    rst = 1'b1;
    #4;
    chk("rst_mack", 32'(m_ack[0]), 32'd0);
    chk("rst_sreq", 32'(s_req[1]), 32'd0);
    step();
    rst = 1'b0; m_req[0] = 1'b0; s_ack[1] = 1'b0;
    #4;
    chk("rst_count", 32'(dut.g_rob[0].u_rob.count), 32'd0);
    chk("rst_mresp", 32'(m_resp[0]), 32'd0);
    chk("rst_mrdata", m_rdata[0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
